// File: rtl/dcache_array_arb_pkg.sv
// Shared dcache array types: request/response bundles and arbiter state.
// Optional perf counters in dcache_array_arb: DCACHE_ARRAY_ARB_PERF_EN.
package dcache_array_arb_pkg;

  localparam int unsigned DC_WAYS   = 4;
  localparam int unsigned DC_IDX_W  = 6;
  localparam int unsigned DC_TAG_W  = 20;
  localparam int unsigned DC_DATA_W = 64;
  localparam int unsigned DC_BE_W   = DC_DATA_W / 8;

  localparam int unsigned ARB_STARVE_LMT = 8;
  localparam int unsigned ARB_CNT_W      = 8;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_e;

  typedef struct packed {
    logic                 we;
    logic [DC_IDX_W-1:0]  idx;
    logic [DC_WAYS-1:0]   way_en;
    logic [DC_DATA_W-1:0] wdata;
    logic [DC_BE_W-1:0]   be;
  } data_req_t;

  typedef struct packed {
    logic                we;
    logic [DC_IDX_W-1:0] idx;
    logic [DC_WAYS-1:0]  way_en;
    logic [DC_TAG_W-1:0] tag;
  } tag_req_t;

  typedef struct packed {
    logic                 we;
    logic                 tag_we;
    logic [DC_IDX_W-1:0]  idx;
    logic [DC_WAYS-1:0]   way_en;
    logic [DC_TAG_W-1:0]  tag;
    logic [DC_DATA_W-1:0] wdata;
    logic [DC_BE_W-1:0]   be;
  } arr_req_t;

  typedef struct packed {
    logic [DC_WAYS-1:0][DC_TAG_W-1:0]  tag;
    logic [DC_WAYS-1:0][DC_DATA_W-1:0] rdata;
  } arr_rsp_t;

  function automatic int unsigned arb_id_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_array_arb_rsp_pipe.sv
// Fixed-latency {vld, id} shift register tracking reads in the SRAM.
// Synchronous clear drops every in-flight entry.
module dcache_array_arb_rsp_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned ID_W  = 1
) (
  input  logic            clk_i,
  input  logic            clr_i,
  input  logic            vld_i,
  input  logic [ID_W-1:0] id_i,
  output logic            vld_o,
  output logic [ID_W-1:0] id_o,
  output logic            busy_o
);

  logic [DEPTH-1:0]           vld_d, vld_q;
  logic [DEPTH-1:0][ID_W-1:0] id_d, id_q;

  // shift one stage per cycle, new entry enters stage 0
  always_comb begin
    vld_d = '0;
    id_d  = '0;
    if (!clr_i) begin
      vld_d[0] = vld_i;
      id_d[0]  = id_i;
      for (int s = 1; s < DEPTH; s++) begin
        vld_d[s] = vld_q[s-1];
        id_d[s]  = id_q[s-1];
      end
    end
  end

  // stage registers
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign id_o   = id_q[DEPTH-1];
  assign busy_o = |vld_q;

endmodule

// File: rtl/dcache_array_arb.sv
// Single-port sequencer for the dcache tag+data arrays: fixed priority
// with starvation escalation, burst lock, fixed-latency response routing.
// Optional perf counters: define DCACHE_ARRAY_ARB_PERF_EN.
module dcache_array_arb
  import dcache_array_arb_pkg::*;
#(
  parameter int unsigned REQ_NUM    = 2,
  parameter int unsigned STARVE_LMT = ARB_STARVE_LMT,
  parameter int unsigned RSP_LAT    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REQ_NUM-1:0]    req_i,
  input  logic [REQ_NUM-1:0]    lock_i,
  input  arr_req_t [REQ_NUM-1:0] req_bits_i,
  output logic [REQ_NUM-1:0]    gnt_o,
  output logic [REQ_NUM-1:0]    rsp_vld_o,
  output arr_rsp_t              rsp_bits_o,
  output logic                  mem_req_o,
  output arr_req_t              mem_req_bits_o,
  input  arr_rsp_t              mem_rsp_bits_i,
  output logic                  busy_o
`ifdef DCACHE_ARRAY_ARB_PERF_EN
  ,
  output logic [31:0]           perf_conflict_o,
  output logic [31:0]           perf_starve_o
`endif
);

  localparam int unsigned ID_W = arb_id_w(REQ_NUM);
  localparam logic [ARB_CNT_W-1:0] LMT = ARB_CNT_W'(STARVE_LMT);

  arb_state_e state_d, state_q;
  logic [ID_W-1:0] owner_d, owner_q;
  logic [REQ_NUM-1:0][ARB_CNT_W-1:0] cnt_d, cnt_q;

  logic [REQ_NUM-1:0] esc;
  logic [REQ_NUM-1:0] gnt;
  logic [ID_W-1:0]    gidx;
  logic               found;
  logic               esc_hit;

  logic               p_vld;
  logic [ID_W-1:0]    p_id;
  logic               p_busy;

  // escalated requesters have waited STARVE_LMT cycles
  always_comb begin
    esc = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      esc[i] = (cnt_q[i] == LMT);
    end
  end

  // grant selection and lock FSM; nothing is granted during reset
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gnt     = '0;
    gidx    = '0;
    found   = 1'b0;
    esc_hit = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          for (int i = 0; i < REQ_NUM; i++) begin
            if (!found && req_i[i] && esc[i]) begin
              gidx    = ID_W'(i);
              found   = 1'b1;
              esc_hit = 1'b1;
            end
          end
          for (int i = 0; i < REQ_NUM; i++) begin
            if (!found && req_i[i]) begin
              gidx  = ID_W'(i);
              found = 1'b1;
            end
          end
          if (found) begin
            gnt[gidx] = 1'b1;
            if (lock_i[gidx]) begin
              state_d = LOCKED;
              owner_d = gidx;
            end
          end
        end
        LOCKED: begin
          if (req_i[owner_q]) begin
            gidx         = owner_q;
            found        = 1'b1;
            gnt[owner_q] = 1'b1;
            if (!lock_i[owner_q]) begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // starvation counters: count denied cycles, saturate at the limit
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (!req_i[i] || gnt[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != LMT) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // FSM, owner and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  dcache_array_arb_rsp_pipe #(
    .DEPTH (RSP_LAT),
    .ID_W  (ID_W)
  ) u_rsp_pipe (
    .clk_i  (clk_i),
    .clr_i  (rst_i),
    .vld_i  (found && !req_bits_i[gidx].we),
    .id_i   (gidx),
    .vld_o  (p_vld),
    .id_o   (p_id),
    .busy_o (p_busy)
  );

  // route the response to the requester that issued the read
  always_comb begin
    rsp_vld_o = '0;
    if (!rst_i && p_vld) begin
      rsp_vld_o[p_id] = 1'b1;
    end
  end

  assign gnt_o          = gnt;
  assign mem_req_o      = |gnt;
  assign mem_req_bits_o = found ? req_bits_i[gidx] : '0;
  assign rsp_bits_o     = (|rsp_vld_o) ? mem_rsp_bits_i : '0;
  assign busy_o         = !rst_i && ((state_q == LOCKED) || p_busy);

`ifdef DCACHE_ARRAY_ARB_PERF_EN
  logic [31:0] conflict_d, conflict_q;
  logic [31:0] starve_d, starve_q;

  // wrapping event counters
  always_comb begin
    conflict_d = conflict_q;
    starve_d   = starve_q;
    if ($countones(req_i) > 1) begin
      conflict_d = conflict_q + 32'd1;
    end
    if (esc_hit) begin
      starve_d = starve_q + 32'd1;
    end
  end

  // perf registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_q <= '0;
      starve_q   <= '0;
    end else begin
      conflict_q <= conflict_d;
      starve_q   <= starve_d;
    end
  end

  assign perf_conflict_o = conflict_q;
  assign perf_starve_o   = starve_q;
`endif

endmodule

// File: tb/tb_dcache_array_arb.sv
// Directed table-driven bench for dcache_array_arb (2 requesters,
// STARVE_LMT=8, RSP_LAT=2) plus reset-mid-lock and perf sequences.
module tb_dcache_array_arb;
  import dcache_array_arb_pkg::*;

  logic                   clk_i;
  logic                   rst_i;
  logic [1:0]             req_i;
  logic [1:0]             lock_i;
  arr_req_t [1:0]         req_bits_i;
  logic [1:0]             gnt_o;
  logic [1:0]             rsp_vld_o;
  arr_rsp_t               rsp_bits_o;
  logic                   mem_req_o;
  arr_req_t               mem_req_bits_o;
  arr_rsp_t               mem_rsp_bits_i;
  logic                   busy_o;
`ifdef DCACHE_ARRAY_ARB_PERF_EN
  logic [31:0]            perf_conflict_o;
  logic [31:0]            perf_starve_o;
`endif

  int n_tot;
  int n_pass;

  dcache_array_arb #(
    .REQ_NUM    (2),
    .STARVE_LMT (8),
    .RSP_LAT    (2)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .lock_i         (lock_i),
    .req_bits_i     (req_bits_i),
    .gnt_o          (gnt_o),
    .rsp_vld_o      (rsp_vld_o),
    .rsp_bits_o     (rsp_bits_o),
    .mem_req_o      (mem_req_o),
    .mem_req_bits_o (mem_req_bits_o),
    .mem_rsp_bits_i (mem_rsp_bits_i),
    .busy_o         (busy_o)
`ifdef DCACHE_ARRAY_ARB_PERF_EN
    ,
    .perf_conflict_o(perf_conflict_o),
    .perf_starve_o  (perf_starve_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] req;
    logic [1:0] lock;
    logic [1:0] we;
    logic [1:0] gnt;
    logic [1:0] rsp;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [1:0] req, input logic [1:0] lock,
                             input logic [1:0] we, input logic [1:0] gnt,
                             input logic [1:0] rsp, input logic busy);
    vec_t x;
    x.req  = req;
    x.lock = lock;
    x.we   = we;
    x.gnt  = gnt;
    x.rsp  = rsp;
    x.busy = busy;
    return x;
  endfunction

  function automatic arr_req_t mk_req(input int r, input logic we);
    arr_req_t b;
    b.we     = we;
    b.tag_we = 1'b0;
    b.idx    = DC_IDX_W'(r * 5 + 3);
    b.way_en = DC_WAYS'(1 << r);
    b.tag    = DC_TAG_W'(32'hA0000 + r);
    b.wdata  = {32'hDEAD0000, 32'(r + 1)};
    b.be     = '1;
    return b;
  endfunction

  function automatic arr_rsp_t mk_rsp(input int k);
    arr_rsp_t p;
    for (int w = 0; w < DC_WAYS; w++) begin
      p.tag[w]   = DC_TAG_W'(k * 16 + w + 1);
      p.rdata[w] = {32'(k), 32'(w + 100)};
    end
    return p;
  endfunction

  function automatic arr_req_t exp_bits(input logic [1:0] g, input logic [1:0] we);
    arr_req_t b;
    b = '0;
    if (g == 2'b01) b = mk_req(0, we[0]);
    if (g == 2'b10) b = mk_req(1, we[1]);
    return b;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] lock,
                       input logic [1:0] we, input int k);
    req_i          = req;
    lock_i         = lock;
    req_bits_i[0]  = mk_req(0, we[0]);
    req_bits_i[1]  = mk_req(1, we[1]);
    mem_rsp_bits_i = mk_rsp(k);
  endtask

  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    n_tot  = 0;
    n_pass = 0;

    // contention: req 1 escalates after 8 denied cycles
    for (int i = 0; i < 8; i++) tbl.push_back(v(2'b11, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0));
    tbl.push_back(v(2'b11, 2'b00, 2'b11, 2'b10, 2'b00, 1'b0));
    tbl.push_back(v(2'b11, 2'b00, 2'b11, 2'b01, 2'b00, 1'b0));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    // single read from req 1, response two cycles later
    tbl.push_back(v(2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    // 4-beat locked write burst from req 0, req 1 reading meanwhile
    tbl.push_back(v(2'b11, 2'b01, 2'b01, 2'b01, 2'b00, 1'b0));
    tbl.push_back(v(2'b11, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1));
    tbl.push_back(v(2'b11, 2'b01, 2'b01, 2'b01, 2'b00, 1'b1));
    tbl.push_back(v(2'b11, 2'b00, 2'b01, 2'b01, 2'b00, 1'b1));
    tbl.push_back(v(2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    // owner drops req while locked: lock kept, others still blocked
    tbl.push_back(v(2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 1'b0));
    tbl.push_back(v(2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
    tbl.push_back(v(2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1));
    tbl.push_back(v(2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1'b1));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    // pipelined alternating reads 0,1,0,1
    tbl.push_back(v(2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
    tbl.push_back(v(2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 1'b1));
    tbl.push_back(v(2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1));
    tbl.push_back(v(2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 1'b1));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1));
    tbl.push_back(v(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));

    // reset state, with requests pending to show they are ignored
    rst_i = 1'b1;
    drive(2'b11, 2'b00, 2'b00, 0);
    next_cyc();
    next_cyc();
    @(negedge clk_i);
    chk("rst gnt", 512'(gnt_o), 512'(0));
    chk("rst mem_req", 512'(mem_req_o), 512'(0));
    chk("rst rsp_vld", 512'(rsp_vld_o), 512'(0));
    chk("rst busy", 512'(busy_o), 512'(0));
    chk("rst mem_bits", 512'(mem_req_bits_o), 512'(0));
    chk("rst rsp_bits", 512'(rsp_bits_o), 512'(0));
    next_cyc();
    rst_i = 1'b0;

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].req, tbl[k].lock, tbl[k].we, k);
      @(negedge clk_i);
      chk($sformatf("v%0d gnt", k), 512'(gnt_o), 512'(tbl[k].gnt));
      chk($sformatf("v%0d mem_req", k), 512'(mem_req_o), 512'(|tbl[k].gnt));
      chk($sformatf("v%0d rsp_vld", k), 512'(rsp_vld_o), 512'(tbl[k].rsp));
      chk($sformatf("v%0d busy", k), 512'(busy_o), 512'(tbl[k].busy));
      chk($sformatf("v%0d mem_bits", k), 512'(mem_req_bits_o),
          512'(exp_bits(tbl[k].gnt, tbl[k].we)));
      chk($sformatf("v%0d rsp_bits", k), 512'(rsp_bits_o),
          (tbl[k].rsp != 2'b00) ? 512'(mk_rsp(k)) : 512'(0));
      next_cyc();
    end

    // reset during beat 2 of a locked read burst from req 0
    drive(2'b11, 2'b01, 2'b00, 200);
    @(negedge clk_i);
    chk("rml b0 gnt", 512'(gnt_o), 512'(2'b01));
    next_cyc();
    @(negedge clk_i);
    chk("rml b1 gnt", 512'(gnt_o), 512'(2'b01));
    chk("rml b1 busy", 512'(busy_o), 512'(1));
    next_cyc();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rml rst gnt", 512'(gnt_o), 512'(0));
    chk("rml rst mem_req", 512'(mem_req_o), 512'(0));
    chk("rml rst rsp_vld", 512'(rsp_vld_o), 512'(0));
    chk("rml rst busy", 512'(busy_o), 512'(0));
    next_cyc();
    rst_i = 1'b0;
    drive(2'b10, 2'b00, 2'b00, 203);
    @(negedge clk_i);
    chk("rml post gnt", 512'(gnt_o), 512'(2'b10));
    chk("rml post rsp_vld", 512'(rsp_vld_o), 512'(0));
    chk("rml post busy", 512'(busy_o), 512'(0));
    next_cyc();
    drive(2'b00, 2'b00, 2'b00, 204);
    @(negedge clk_i);
    chk("rml +1 rsp_vld", 512'(rsp_vld_o), 512'(0));
    chk("rml +1 busy", 512'(busy_o), 512'(1));
    next_cyc();
    drive(2'b00, 2'b00, 2'b00, 205);
    @(negedge clk_i);
    chk("rml +2 rsp_vld", 512'(rsp_vld_o), 512'(2'b10));
    chk("rml +2 rsp_bits", 512'(rsp_bits_o), 512'(mk_rsp(205)));
    next_cyc();

`ifdef DCACHE_ARRAY_ARB_PERF_EN
    rst_i = 1'b1;
    next_cyc();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("perf rst conflict", 512'(perf_conflict_o), 512'(0));
    chk("perf rst starve", 512'(perf_starve_o), 512'(0));
    next_cyc();
    for (int c = 0; c < 12; c++) begin
      drive(2'b11, 2'b00, 2'b11, 300 + c);
      next_cyc();
    end
    drive(2'b00, 2'b00, 2'b00, 320);
    @(negedge clk_i);
    chk("perf conflict", 512'(perf_conflict_o), 512'(12));
    chk("perf starve", 512'(perf_starve_o), 512'(1));
    next_cyc();
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dcache_array_arb.md
Name: dcache_array_arb

Overview:
- Arbiter/sequencer for the shared dcache tag+data SRAM arrays.
- Arbitrates REQ_NUM requesters: index 0 = miss unit (refill/probe/writeback), index 1 = dcache ctrl (LSU/MMU/MSHR replay), optional index 2 = flush walker.
- Provides fixed priority with starvation escalation, multi-beat lock for bursts, and response routing after fixed SRAM latency.
- Sits between the requester modules and dcache_mem; the memory sees a single port.

Parameters:
- REQ_NUM, 2, number of requesters (2..4).
- STARVE_LMT, 8, consecutive denied cycles before a requester is escalated (range 2..255).
- RSP_LAT, 1, SRAM read latency in cycles (range 1..3).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  REQ_NUM  per-requester access request; held until granted.
- lock_i  in  REQ_NUM  sampled at grant: 1 = more beats follow and the owner keeps the arrays.
- req_bits_i  in  REQ_NUM x arr_req_t  {we, tag_we, idx, way_en, tag, wdata, be}.
- gnt_o  out  REQ_NUM  one-hot grant; the beat is accepted this cycle.
- rsp_vld_o  out  REQ_NUM  read data valid for the requester whose read was granted RSP_LAT cycles earlier.
- rsp_bits_o  out  arr_rsp_t  {tag[], rdata[]}; broadcast to all requesters, qualified by rsp_vld_o.
- mem_req_o  out  1  access to dcache_mem this cycle.
- mem_req_bits_o  out  arr_req_t  muxed request bits of the granted requester.
- mem_rsp_bits_i  in  arr_rsp_t  raw SRAM output.
- busy_o  out  1  lock held, or read response still in flight.

Behaviour:
- Reset values: every output 0; FSM = IDLE; starvation counters 0; response pipe cleared.
- Grant is combinational from req_i and state:
  - gnt_o is one-hot or zero.
  - mem_req_o = |gnt_o.
  - mem_req_bits_o = req_bits_i[granted index] (all zeros when no grant).
- FSM:
  - IDLE: grant per the priority rules below. Grant with lock_i=1 moves to LOCKED(owner=i).
  - LOCKED: only the owner can be granted; all others see gnt=0. Owner grant with lock_i=0 (last beat) returns to IDLE next cycle.
  - If the owner drops req_i while LOCKED, the lock is kept. There is no timeout.
- Priority in IDLE:
  - Any escalated requester (counter == STARVE_LMT) wins; if several are escalated, the lowest index wins.
  - Otherwise the lowest requesting index wins.
- Starvation counter i:
  - Increments, saturating at STARVE_LMT, in each cycle where req_i[i]=1 and gnt_o[i]=0.
  - Clears on gnt_o[i] and whenever req_i[i]=0.
- Response pipe (RSP_LAT-deep):
  - Carries {vld, id}; vld = grant with we=0.
  - rsp_vld_o[id] = 1 exactly RSP_LAT cycles after the grant.
  - Write beats produce no response.
- Back-to-back: a new grant is allowed every cycle; responses are pipelined, not blocking.
- Reset mid-lock: state returns to IDLE and in-flight responses are discarded (rsp_vld_o=0 the next cycle).
- Simultaneous events: in the cycle where the last-beat grant is issued, no other requester is granted. Others become grantable the following cycle.

Optional Feature:
- Macro DCACHE_ARRAY_ARB_PERF_EN.
- Defined: adds outputs perf_conflict_o (32 bits) and perf_starve_o (32 bits), both wrapping counters reset to 0.
  - perf_conflict_o counts cycles with ≥2 req_i asserted.
  - perf_starve_o counts escalated grants.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- arr_req_t, arr_rsp_t, arb_state_e {IDLE, LOCKED}, and the STARVE_LMT default go in the dcache package, beside data_req_t and tag_req_t.
- Sub-module dcache_array_arb_rsp_pipe: a parameterised RSP_LAT-stage {vld, id} shift register with synchronous clear.

Test Plan:
- Contention: req_i=2'b11 for 10 cycles, STARVE_LMT=8, no lock -> gnt_o=01 cycles 0-7, gnt_o=10 at cycle 8 (escalated), then 01 resumes.
- Read latency: single read from req 1 at cycle 5, RSP_LAT=2 -> rsp_vld_o=10 at cycle 7 only; rsp_bits_o equals mem_rsp_bits_i at cycle 7.
- Burst lock: req 0 issues 4 write beats with lock_i=1,1,1,0 while req 1 requests continuously -> req 1 is denied for all 4 beats, granted on cycle 5; no rsp_vld_o is generated.
- Reset mid-lock: rst_i at beat 2 of a locked read burst -> next cycle all outputs are 0; after release, req 1 is granted immediately.
- Pipelined reads: alternating single reads 0,1,0,1 every cycle -> rsp_vld_o=01,10,01,10 RSP_LAT cycles later in order.
- Perf (macro on): 12 cycles with req_i=2'b11 -> perf_conflict_o=12, perf_starve_o=1.
